// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding select, load-use / long-latency hazard stall,
// and a per-register busy scoreboard for outstanding long-latency writes.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   src_rs_i/use_i    consumer source regs and read-enables (NSRC)
//   stg_rd_i/we_i/rdy_i  producer dest reg, write, result-ready (NSTG)
//   ll_issue_i/rd_i   long-latency op issue request and its dest reg
//   ll_done_i/rd_i    long-latency writeback this cycle and its dest reg
//   fwd_sel_o         per-operand select: 0 = regfile, s = stage s-1
//   stall_o           hold consumer in ID
//   sb_busy_o         pending long-latency write per register
//   stall_cnt_o       saturating stalled-cycle counter
module fwd_hazard_scoreboard #(
  parameter int NSRC = 2,
  parameter int NSTG = 2,
  parameter int RAW  = 5,
  parameter int CNTW = 16,
  localparam int NREG = 2**RAW,
  localparam int SELW = $clog2(NSTG+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC*RAW-1:0]  src_rs_i,
  input  logic [NSRC-1:0]      src_use_i,
  input  logic [NSTG*RAW-1:0]  stg_rd_i,
  input  logic [NSTG-1:0]      stg_we_i,
  input  logic [NSTG-1:0]      stg_rdy_i,
  input  logic                 ll_issue_i,
  input  logic [RAW-1:0]       ll_rd_i,
  input  logic                 ll_done_i,
  input  logic [RAW-1:0]       ll_done_rd_i,
  output logic [NSRC*SELW-1:0] fwd_sel_o,
  output logic                 stall_o,
  output logic [NREG-1:0]      sb_busy_o,
  output logic [CNTW-1:0]      stall_cnt_o
);

  logic [NREG-1:0] sb_q, sb_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [NREG-1:0] done_mask;
  logic [NREG-1:0] busy_eff;

  logic [NSRC-1:0][SELW-1:0] sel;
  logic [NSRC-1:0]           ld_use;
  logic [NSRC-1:0]           raw_hz;
  logic                      waw_hz;
  logic                      stall;

  assign done_mask = ll_done_i
                   ? (NREG'(1) << ll_done_rd_i)
                   : '0;

  // A register completing this cycle no longer blocks anyone.
  assign busy_eff = sb_q & ~done_mask;

  always_comb begin
    sel    = '0;
    ld_use = '0;
    raw_hz = '0;
    for (int i = 0; i < NSRC; i++) begin
      logic [RAW-1:0] rs;
      logic           hit;
      logic           rdy;
      rs  = src_rs_i[i*RAW +: RAW];
      hit = 1'b0;
      rdy = 1'b1;
      // Walk farthest to nearest so the nearest match is kept.
      for (int s = NSTG-1; s >= 0; s--) begin
        if (stg_we_i[s] && src_use_i[i] &&
            (stg_rd_i[s*RAW +: RAW] != '0) &&
            (stg_rd_i[s*RAW +: RAW] == rs)) begin
          hit    = 1'b1;
          sel[i] = SELW'(s + 1);
          rdy    = stg_rdy_i[s];
        end
      end
      ld_use[i] = hit && !rdy;
      raw_hz[i] = src_use_i[i] && (rs != '0)
                && busy_eff[rs] && !hit;
    end
  end

  assign waw_hz = ll_issue_i && (ll_rd_i != '0)
                && busy_eff[ll_rd_i];

  assign stall = (|ld_use) || (|raw_hz) || waw_hz;

  always_comb begin
    sb_d = sb_q & ~done_mask;
    if (ll_issue_i && !stall && (ll_rd_i != '0))
      sb_d[ll_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNTW{1'b1}}))
      cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign fwd_sel_o   = sel;
  assign stall_o     = stall;
  assign sb_busy_o   = sb_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Randomized + directed bench for fwd_hazard_scoreboard
// against a behavioural reference model.
module tb_fwd_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  src_rs;
  logic [1:0]  src_use;
  logic [9:0]  stg_rd;
  logic [1:0]  stg_we;
  logic [1:0]  stg_rdy;
  logic        ll_issue;
  logic [4:0]  ll_rd;
  logic        ll_done;
  logic [4:0]  ll_done_rd;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [31:0] sb_busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_busy;
  int          m_cnt;

  fwd_hazard_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .src_rs_i     (src_rs),
    .src_use_i    (src_use),
    .stg_rd_i     (stg_rd),
    .stg_we_i     (stg_we),
    .stg_rdy_i    (stg_rdy),
    .ll_issue_i   (ll_issue),
    .ll_rd_i      (ll_rd),
    .ll_done_i    (ll_done),
    .ll_done_rd_i (ll_done_rd),
    .fwd_sel_o    (fwd_sel),
    .stall_o      (stall),
    .sb_busy_o    (sb_busy),
    .stall_cnt_o  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(output logic [3:0] esel,
                                output logic est);
    logic [31:0] be;
    be = m_busy;
    if (ll_done) be[ll_done_rd] = 1'b0;
    esel = '0;
    est  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [4:0] rs;
      int hit;
      rs  = src_rs[i*5 +: 5];
      hit = -1;
      for (int s = 0; s < 2; s++)
        if (hit < 0 && src_use[i] && stg_we[s] &&
            stg_rd[s*5 +: 5] != 0 && stg_rd[s*5 +: 5] == rs)
          hit = s;
      if (hit >= 0) begin
        esel[i*2 +: 2] = 2'(hit + 1);
        if (!stg_rdy[hit]) est = 1'b1;
      end else if (src_use[i] && rs != 0 && be[rs]) begin
        est = 1'b1;
      end
    end
    if (ll_issue && ll_rd != 0 && be[ll_rd]) est = 1'b1;
  endfunction

  task automatic idle();
    src_rs = '0; src_use = '0;
    stg_rd = '0; stg_we = '0; stg_rdy = 2'b11;
    ll_issue = 0; ll_rd = '0;
    ll_done = 0; ll_done_rd = '0;
  endtask

  // Check outputs for the current inputs, then clock and advance model.
  task automatic step(input string tag);
    logic [3:0] esel;
    logic       est;
    #1;
    model(esel, est);
    chk({tag, ".sel"},  32'(fwd_sel),   32'(esel));
    chk({tag, ".stl"},  32'(stall),     32'(est));
    chk({tag, ".busy"}, sb_busy,        m_busy);
    chk({tag, ".cnt"},  32'(stall_cnt), 32'(m_cnt));
    @(posedge clk);
    if (ll_done) m_busy[ll_done_rd] = 1'b0;
    if (ll_issue && !est && ll_rd != 0) m_busy[ll_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (est && m_cnt < 65535) m_cnt++;
    #1;
  endtask

  initial begin
    int r;
    idle();
    rst_n  = 1'b0;
    m_busy = '0;
    m_cnt  = 0;
    #12;
    chk("rst.busy", sb_busy, 32'h0);
    chk("rst.cnt",  32'(stall_cnt), 32'h0);
    chk("rst.sel",  32'(fwd_sel), 32'h0);
    chk("rst.stl",  32'(stall), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: nearest stage wins
    idle();
    stg_we = 2'b11; stg_rd = {5'd5, 5'd5};
    src_rs = {5'd0, 5'd5}; src_use = 2'b01;
    #1;
    chk("t1.sel0", 32'(fwd_sel[1:0]), 32'd1);
    step("t1");

    // 2: load-use then data ready
    idle();
    stg_we = 2'b01; stg_rd = {5'd0, 5'd7}; stg_rdy = 2'b10;
    src_rs = {5'd7, 5'd0}; src_use = 2'b10;
    #1;
    chk("t2.stl", 32'(stall), 32'd1);
    chk("t2.sel1", 32'(fwd_sel[3:2]), 32'd1);
    step("t2a");
    stg_rdy = 2'b11;
    step("t2b");

    // 3: long-latency issue, RAW stall, release on done
    idle();
    ll_issue = 1; ll_rd = 5'd9;
    step("t3a");
    idle();
    chk("t3.busy9", 32'(sb_busy[9]), 32'd1);
    src_rs = {5'd0, 5'd9}; src_use = 2'b01;
    #1;
    chk("t3.raw", 32'(stall), 32'd1);
    step("t3b");
    step("t3c");
    ll_done = 1; ll_done_rd = 5'd9;
    #1;
    chk("t3.rel", 32'(stall), 32'd0);
    step("t3d");

    // 4: same-cycle done and reissue to x9
    idle();
    ll_issue = 1; ll_rd = 5'd9;
    step("t4a");
    ll_done = 1; ll_done_rd = 5'd9;
    #1;
    chk("t4.stl", 32'(stall), 32'd0);
    step("t4b");
    chk("t4.busy9", 32'(sb_busy[9]), 32'd1);
    idle();
    ll_done = 1; ll_done_rd = 5'd9;
    step("t4c");

    // 5: x0 is never forwarded, stalled or tracked
    idle();
    stg_we = 2'b11; stg_rdy = 2'b00;
    src_use = 2'b11;
    ll_issue = 1; ll_rd = 5'd0;
    #1;
    chk("t5.sel", 32'(fwd_sel), 32'd0);
    chk("t5.stl", 32'(stall), 32'd0);
    step("t5");
    chk("t5.busy", sb_busy, 32'h0);

    // random phase
    for (int n = 0; n < 3000; n++) begin
      src_rs   = {5'($urandom_range(7)), 5'($urandom_range(7))};
      src_use  = 2'($urandom);
      stg_rd   = {5'($urandom_range(7)), 5'($urandom_range(7))};
      stg_we   = 2'($urandom);
      stg_rdy  = ($urandom_range(3) != 0) ? 2'b11 : 2'($urandom);
      ll_issue = ($urandom_range(3) == 0);
      ll_rd    = 5'($urandom_range(7));
      ll_done  = ($urandom_range(2) == 0);
      ll_done_rd = 5'($urandom_range(7));
      step("rnd");
    end

    // 6: saturate counter, then async reset mid-run
    idle();
    r = 0;
    for (int k = 1; k < 32; k++)
      if (r == 0 && !m_busy[k]) r = k;
    ll_issue = 1; ll_rd = 5'(r);
    step("t6a");
    idle();
    stg_we = 2'b01; stg_rd = {5'd0, 5'd3}; stg_rdy = 2'b10;
    src_rs = {5'd0, 5'd3}; src_use = 2'b01;
    step("t6b");
    for (int n = 0; n < 70000; n++) begin
      @(posedge clk);
      if (m_cnt < 65535) m_cnt++;
    end
    #1;
    chk("t6.sat", 32'(stall_cnt), 32'(m_cnt));
    chk("t6.ffff", 32'(stall_cnt), 32'hFFFF);
    step("t6c");
    chk("t6.hold", 32'(stall_cnt), 32'hFFFF);
    chk("t6.pend", 32'(sb_busy[r]), 32'd1);
    #2;
    rst_n = 1'b0;
    m_busy = '0;
    m_cnt  = 0;
    #1;
    chk("t6.rbusy", sb_busy, 32'h0);
    chk("t6.rcnt",  32'(stall_cnt), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    step("t6d");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
